// File: rtl/adc_trigger_responder.sv
// Receive-side trigger handshake: edge-detects the trigger line, returns a four-phase
// acknowledge and writes a programmed number of ADC samples into acquisition RAM.
module adc_trigger_responder #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DLY_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irArm,
    input  logic [ADDR_W-1:0] irRecordLength,
    input  logic [DLY_W-1:0]  irTrigDelay,
    input  logic              irTriggerLine,
    output logic              orTriggerAck,
    input  logic [DATA_W-1:0] irAdcData,
    input  logic              irAdcValid,
    output logic [ADDR_W-1:0] orRamWriteAddr,
    output logic [DATA_W-1:0] orRamWriteData,
    output logic              orRamWriteEn,
    input  logic              irInterruptClear,
    output logic              orInterrupt,
    output logic              orMissedTrig,
    output logic              orBusy
);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StDelay,
        StCapture,
        StDone
    } state_e;

    state_e            state;
    logic              trig_q;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] samp_cnt;
    logic [DLY_W-1:0]  dly_cnt;

    logic rise;
    logic last_samp;
    logic done_set;
    logic missed_set;

    assign rise      = irTriggerLine & ~trig_q;
    assign last_samp = (samp_cnt + ADDR_W'(1)) == len_r;
    // A zero-length record completes on the accepting trigger edge itself.
    assign done_set  = ((state == StArmed) & irArm & rise & (irRecordLength == '0)) |
                       ((state == StCapture) & irAdcValid & last_samp);
    assign missed_set = rise & (state != StArmed);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            trig_q         <= 1'b0;
            len_r          <= '0;
            samp_cnt       <= '0;
            dly_cnt        <= '0;
            orTriggerAck   <= 1'b0;
            orRamWriteAddr <= '0;
            orRamWriteData <= '0;
            orRamWriteEn   <= 1'b0;
            orInterrupt    <= 1'b0;
            orMissedTrig   <= 1'b0;
            orBusy         <= 1'b0;
        end else begin
            trig_q       <= irTriggerLine;
            orRamWriteEn <= 1'b0;

            // Ack follows the line regardless of state so the transmitter never stalls.
            if (rise) begin
                orTriggerAck <= 1'b1;
            end else if (!irTriggerLine) begin
                orTriggerAck <= 1'b0;
            end

            if (done_set) begin
                orInterrupt <= 1'b1;
            end else if (irInterruptClear) begin
                orInterrupt <= 1'b0;
            end

            if (missed_set) begin
                orMissedTrig <= 1'b1;
            end else if (irInterruptClear) begin
                orMissedTrig <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (irArm) state <= StArmed;
                end
                StArmed: begin
                    if (!irArm) begin
                        state <= StIdle;
                    end else if (rise) begin
                        len_r    <= irRecordLength;
                        dly_cnt  <= irTrigDelay;
                        samp_cnt <= '0;
                        if (irRecordLength == '0) begin
                            state <= StDone;
                        end else if (irTrigDelay == '0) begin
                            state  <= StCapture;
                            orBusy <= 1'b1;
                        end else begin
                            state  <= StDelay;
                            orBusy <= 1'b1;
                        end
                    end
                end
                StDelay: begin
                    dly_cnt <= dly_cnt - DLY_W'(1);
                    if (dly_cnt == DLY_W'(1)) state <= StCapture;
                end
                StCapture: begin
                    if (irAdcValid) begin
                        orRamWriteEn   <= 1'b1;
                        orRamWriteAddr <= samp_cnt;
                        orRamWriteData <= irAdcData;
                        samp_cnt       <= samp_cnt + ADDR_W'(1);
                        if (last_samp) begin
                            state  <= StDone;
                            orBusy <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (!irArm) state <= StIdle;
                end
                default: begin
                    state  <= StIdle;
                    orBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_trigger_responder.sv
// Directed bench for adc_trigger_responder: handshake, delay, capture, flags and reset abort.
module tb_adc_trigger_responder;

    localparam int unsigned DATA_W = 96;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DLY_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              irArm;
    logic [ADDR_W-1:0] irRecordLength;
    logic [DLY_W-1:0]  irTrigDelay;
    logic              irTriggerLine;
    logic              orTriggerAck;
    logic [DATA_W-1:0] irAdcData;
    logic              irAdcValid;
    logic [ADDR_W-1:0] orRamWriteAddr;
    logic [DATA_W-1:0] orRamWriteData;
    logic              orRamWriteEn;
    logic              irInterruptClear;
    logic              orInterrupt;
    logic              orMissedTrig;
    logic              orBusy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adc_trigger_responder #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DLY_W (DLY_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .irArm           (irArm),
        .irRecordLength  (irRecordLength),
        .irTrigDelay     (irTrigDelay),
        .irTriggerLine   (irTriggerLine),
        .orTriggerAck    (orTriggerAck),
        .irAdcData       (irAdcData),
        .irAdcValid      (irAdcValid),
        .orRamWriteAddr  (orRamWriteAddr),
        .orRamWriteData  (orRamWriteData),
        .orRamWriteEn    (orRamWriteEn),
        .irInterruptClear(irInterruptClear),
        .orInterrupt     (orInterrupt),
        .orMissedTrig    (orMissedTrig),
        .orBusy          (orBusy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    task automatic chk_wr(input string tag, input int addr, input logic [DATA_W-1:0] data);
        chk1({tag, "_en"}, orRamWriteEn, 1'b1);
        chk({tag, "_addr"}, 128'(orRamWriteAddr), 128'(addr));
        chk({tag, "_data"}, 128'(orRamWriteData), 128'(data));
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] smp(input int i);
        return {32'hCAFE_0000 + 32'(i), 32'h0BAD_F00D, ~32'(i)};
    endfunction

    initial begin
        rst = 1'b1;
        irArm = 1'b0;
        irRecordLength = '0;
        irTrigDelay = '0;
        irTriggerLine = 1'b0;
        irAdcData = '0;
        irAdcValid = 1'b0;
        irInterruptClear = 1'b0;
        step();
        step();
        chk1("rst_ack", orTriggerAck, 1'b0);
        chk1("rst_wren", orRamWriteEn, 1'b0);
        chk1("rst_irq", orInterrupt, 1'b0);
        chk1("rst_missed", orMissedTrig, 1'b0);
        chk1("rst_busy", orBusy, 1'b0);
        chk("rst_addr", 128'(orRamWriteAddr), 128'(0));
        chk("rst_data", 128'(orRamWriteData), 128'(0));
        rst = 1'b0;

        // Basic capture: no delay, 4 samples, trigger held for 10 cycles.
        irArm = 1'b1;
        irRecordLength = 15'd4;
        irTrigDelay = 16'd0;
        step();
        irTriggerLine = 1'b1;
        step();
        chk1("t1_ack", orTriggerAck, 1'b1);
        chk1("t1_busy", orBusy, 1'b1);
        chk1("t1_nowr", orRamWriteEn, 1'b0);
        for (int i = 0; i < 4; i++) begin
            irAdcValid = 1'b1;
            irAdcData = smp(i);
            step();
            chk_wr("t1_wr", i, smp(i));
            chk1("t1_irq", orInterrupt, i == 3);
            chk1("t1_busy_w", orBusy, i != 3);
        end
        irAdcValid = 1'b0;
        irAdcData = smp(99);
        step();
        chk1("t1_wr_idle", orRamWriteEn, 1'b0);
        chk1("t1_irq_hold", orInterrupt, 1'b1);
        repeat (4) step();
        chk1("t2_ack_held", orTriggerAck, 1'b1);
        irTriggerLine = 1'b0;
        #1;
        chk1("t2_ack_low_sample", orTriggerAck, 1'b1);
        step();
        chk1("t2_ack_drop", orTriggerAck, 1'b0);
        irInterruptClear = 1'b1;
        step();
        irInterruptClear = 1'b0;
        chk1("t2_irq_clr", orInterrupt, 1'b0);
        irArm = 1'b0;
        step();

        // Delay of 5 with a strobe every cycle from the trigger onwards.
        irArm = 1'b1;
        irRecordLength = 15'd2;
        irTrigDelay = 16'd5;
        step();
        irTriggerLine = 1'b1;
        irAdcValid = 1'b1;
        irAdcData = smp(100);
        step();
        chk1("t3_busy", orBusy, 1'b1);
        chk1("t3_nowr0", orRamWriteEn, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            irAdcData = smp(100 + k);
            step();
            chk1("t3_nowr", orRamWriteEn, 1'b0);
            chk1("t3_busy_d", orBusy, 1'b1);
        end
        irAdcData = smp(106);
        step();
        chk_wr("t3_wr0", 0, smp(106));
        irAdcData = smp(107);
        step();
        chk_wr("t3_wr1", 1, smp(107));
        chk1("t3_irq", orInterrupt, 1'b1);
        chk1("t3_busy_end", orBusy, 1'b0);
        irAdcValid = 1'b0;
        irTriggerLine = 1'b0;
        step();
        irArm = 1'b0;
        irInterruptClear = 1'b1;
        step();
        irInterruptClear = 1'b0;
        chk1("t3_irq_clr", orInterrupt, 1'b0);

        // Missed triggers in IDLE and CAPTURE; clear coincides with completion.
        irTriggerLine = 1'b1;
        step();
        chk1("t4_idle_ack", orTriggerAck, 1'b1);
        chk1("t4_idle_missed", orMissedTrig, 1'b1);
        chk1("t4_idle_busy", orBusy, 1'b0);
        irTriggerLine = 1'b0;
        step();
        chk1("t4_ack_drop", orTriggerAck, 1'b0);
        irArm = 1'b1;
        irRecordLength = 15'd3;
        irTrigDelay = 16'd0;
        step();
        irTriggerLine = 1'b1;
        step();
        chk1("t4_cap_busy", orBusy, 1'b1);
        irTriggerLine = 1'b0;
        irAdcValid = 1'b1;
        irAdcData = smp(200);
        step();
        chk_wr("t4_wr0", 0, smp(200));
        irTriggerLine = 1'b1;
        irAdcData = smp(201);
        step();
        chk_wr("t4_wr1", 1, smp(201));
        chk1("t4_cap_ack", orTriggerAck, 1'b1);
        chk1("t4_cap_missed", orMissedTrig, 1'b1);
        irAdcData = smp(202);
        irInterruptClear = 1'b1;
        step();
        chk_wr("t4_wr2", 2, smp(202));
        chk1("t4_irq_wins", orInterrupt, 1'b1);
        chk1("t4_missed_clr", orMissedTrig, 1'b0);
        chk1("t4_busy_end", orBusy, 1'b0);
        irAdcValid = 1'b0;
        irInterruptClear = 1'b0;
        irTriggerLine = 1'b0;
        step();
        irArm = 1'b0;
        irInterruptClear = 1'b1;
        step();
        irInterruptClear = 1'b0;

        // Zero-length record completes on the trigger edge with no writes.
        irArm = 1'b1;
        irRecordLength = 15'd0;
        irTrigDelay = 16'd3;
        step();
        irTriggerLine = 1'b1;
        step();
        chk1("t5_ack", orTriggerAck, 1'b1);
        chk1("t5_irq", orInterrupt, 1'b1);
        chk1("t5_busy", orBusy, 1'b0);
        chk1("t5_nowr", orRamWriteEn, 1'b0);
        irAdcValid = 1'b1;
        irAdcData = smp(300);
        step();
        chk1("t5_done_discard", orRamWriteEn, 1'b0);
        irAdcValid = 1'b0;
        irTriggerLine = 1'b0;
        irArm = 1'b0;
        step();
        irInterruptClear = 1'b1;
        step();
        irInterruptClear = 1'b0;
        chk1("t5_irq_clr", orInterrupt, 1'b0);

        // Reset in the middle of an 8-sample record with the line still high.
        irArm = 1'b1;
        irRecordLength = 15'd8;
        irTrigDelay = 16'd0;
        step();
        irTriggerLine = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            irAdcValid = 1'b1;
            irAdcData = smp(400 + i);
            step();
            chk_wr("t6_wr", i, smp(400 + i));
        end
        irAdcValid = 1'b0;
        rst = 1'b1;
        step();
        chk1("t6_ack", orTriggerAck, 1'b0);
        chk1("t6_wren", orRamWriteEn, 1'b0);
        chk1("t6_busy", orBusy, 1'b0);
        chk1("t6_irq", orInterrupt, 1'b0);
        chk1("t6_missed", orMissedTrig, 1'b0);
        chk("t6_addr", 128'(orRamWriteAddr), 128'(0));
        irTriggerLine = 1'b0;
        step();
        rst = 1'b0;
        irRecordLength = 15'd2;
        step();
        irTriggerLine = 1'b1;
        step();
        chk1("t6_retrig_ack", orTriggerAck, 1'b1);
        irAdcValid = 1'b1;
        irAdcData = smp(500);
        step();
        chk_wr("t6_rwr0", 0, smp(500));
        irAdcData = smp(501);
        step();
        chk_wr("t6_rwr1", 1, smp(501));
        chk1("t6_rirq", orInterrupt, 1'b1);
        irAdcValid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
